// File: rtl/univ_shift_reg_if.sv
// Interface bundling the data/control signals of the universal shift register.
// The master side drives controls and data; the slave side is the register.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH);

  logic             en;
  logic [1:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] out;
  logic             so_r;
  logic             so_l;
  logic [CW-1:0]    cnt;
  logic             word_done;

  modport master (
    output en, mode, sin_r, sin_l, pin,
    input  out, so_r, so_l, cnt, word_done
  );

  modport slave (
    input  en, mode, sin_r, sin_l, pin,
    output out, so_r, so_l, cnt, word_done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load.
// Counts shift edges in either direction and pulses word_done for one cycle
// each time WIDTH shifts complete a word. A load or reset discards a partial word.
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic             clk,
  input logic             rst,
  univ_shift_reg_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] out_q, out_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             done_q, done_nxt;
  logic             shift;

  // Next-state: data path selection, shared shift counter, word-done pulse.
  always_comb begin
    out_nxt  = out_q;
    cnt_nxt  = cnt_q;
    done_nxt = 1'b0;
    shift    = 1'b0;
    if (bus.en) begin
      case (mode_e'(bus.mode))
        MODE_RIGHT: begin
          out_nxt = {bus.sin_r, out_q[WIDTH-1:1]};
          shift   = 1'b1;
        end
        MODE_LEFT: begin
          out_nxt = {out_q[WIDTH-2:0], bus.sin_l};
          shift   = 1'b1;
        end
        MODE_LOAD: begin
          out_nxt = bus.pin;
          cnt_nxt = '0;
        end
        default: ;
      endcase
    end
    // Both directions advance the same counter so a mid-word turn keeps the count.
    if (shift) begin
      if (cnt_q == CNT_LAST) begin
        cnt_nxt  = '0;
        done_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt_q + CW'(1);
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q  <= RST_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_nxt;
      cnt_q  <= cnt_nxt;
      done_q <= done_nxt;
    end
  end

  // Serial outputs are direct taps of the register, no extra stage.
  assign bus.out       = out_q;
  assign bus.cnt       = cnt_q;
  assign bus.word_done = done_q;
  assign bus.so_r      = out_q[0];
  assign bus.so_l      = out_q[WIDTH-1];
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg, WIDTH=8, RST_VAL=0.
module tb_univ_shift_reg;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  univ_shift_reg_if #(.WIDTH(8)) bus ();

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [1:0] mode, input logic sr,
                       input logic sl, input logic [7:0] pin);
    bus.en    = en;
    bus.mode  = mode;
    bus.sin_r = sr;
    bus.sin_l = sl;
    bus.pin   = pin;
  endtask

  task automatic load(input logic [7:0] v);
    drive(1'b1, 2'b11, 1'b0, 1'b0, v);
    step();
  endtask

  task automatic test_reset();
    // power-on reset
    #1;
    checks++;
    if (bus.out !== 8'h00 || bus.cnt !== 3'd0 || bus.word_done !== 1'b0) begin
      failures++;
      $display("FAIL por: out=%h cnt=%0d wd=%b required 00/0/0", bus.out, bus.cnt, bus.word_done);
    end
    #2 rst = 1'b1;
    load(8'hA5);
    drive(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
    step();
    step();
    // async reset between edges
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.out !== 8'h00 || bus.cnt !== 3'd0 || bus.word_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: out=%h cnt=%0d wd=%b required 00/0/0", bus.out, bus.cnt, bus.word_done);
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_load_right();
    logic [7:0] sor_exp;
    sor_exp = 8'hA5;
    load(8'hA5);
    checks++;
    if (bus.out !== 8'hA5 || bus.cnt !== 3'd0) begin
      failures++;
      $display("FAIL load_a5: out=%h cnt=%0d required a5/0", bus.out, bus.cnt);
    end
    drive(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.so_r !== sor_exp[i]) begin
        failures++;
        $display("FAIL so_r_bit%0d: got %b required %b", i, bus.so_r, sor_exp[i]);
      end
      step();
      checks++;
      if (bus.word_done !== (i == 7)) begin
        failures++;
        $display("FAIL right_wd_shift%0d: got %b required %b", i + 1, bus.word_done, (i == 7));
      end
    end
    checks++;
    if (bus.out !== 8'hFF || bus.cnt !== 3'd0 || bus.so_l !== 1'b1) begin
      failures++;
      $display("FAIL right_final: out=%h cnt=%0d so_l=%b required ff/0/1", bus.out, bus.cnt, bus.so_l);
    end
    drive(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
    step();
    checks++;
    if (bus.word_done !== 1'b0 || bus.out !== 8'hFF || bus.cnt !== 3'd0) begin
      failures++;
      $display("FAIL hold_after_word: wd=%b out=%h cnt=%0d required 0/ff/0", bus.word_done, bus.out, bus.cnt);
    end
  endtask

  task automatic test_left();
    logic [3:0] sl_seq;
    logic [7:0] exp_out [4];
    sl_seq = 4'b0011;  // applied LSB first: 1,1,0,0
    exp_out = '{8'h01, 8'h03, 8'h06, 8'h0C};
    load(8'h00);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b10, 1'b0, sl_seq[i], 8'h00);
      step();
      checks++;
      if (bus.out !== exp_out[i] || bus.cnt !== 3'(i + 1)) begin
        failures++;
        $display("FAIL left_shift%0d: out=%h cnt=%0d required %h/%0d", i + 1, bus.out, bus.cnt, exp_out[i], i + 1);
      end
    end
    drive(1'b1, 2'b00, 1'b1, 1'b1, 8'hFF);
    step();
    checks++;
    if (bus.out !== 8'h0C || bus.cnt !== 3'd4) begin
      failures++;
      $display("FAIL hold_mode: out=%h cnt=%0d required 0c/4", bus.out, bus.cnt);
    end
  endtask

  task automatic test_enable_low();
    load(8'h3C);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b01, 1'b1, 1'b1, 8'hFF);
      step();
      checks++;
      if (bus.out !== 8'h3C || bus.cnt !== 3'd0 || bus.word_done !== 1'b0) begin
        failures++;
        $display("FAIL en_low%0d: out=%h cnt=%0d wd=%b required 3c/0/0", i, bus.out, bus.cnt, bus.word_done);
      end
    end
  endtask

  task automatic test_load_interrupt();
    logic [7:0] exp_out [2];
    exp_out = '{8'h40, 8'h20};
    load(8'h00);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (bus.cnt !== 3'd6) begin
      failures++;
      $display("FAIL six_shifts_cnt: got %0d required 6", bus.cnt);
    end
    load(8'h81);
    checks++;
    if (bus.out !== 8'h81 || bus.cnt !== 3'd0 || bus.word_done !== 1'b0 ||
        bus.so_r !== 1'b1 || bus.so_l !== 1'b1) begin
      failures++;
      $display("FAIL load_81: out=%h cnt=%0d wd=%b so_r=%b so_l=%b required 81/0/0/1/1",
               bus.out, bus.cnt, bus.word_done, bus.so_r, bus.so_l);
    end
    drive(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.out !== exp_out[i] || bus.cnt !== 3'(i + 1) || bus.word_done !== 1'b0) begin
        failures++;
        $display("FAIL post_load_shift%0d: out=%h cnt=%0d wd=%b required %h/%0d/0",
                 i + 1, bus.out, bus.cnt, bus.word_done, exp_out[i], i + 1);
      end
    end
  endtask

  task automatic test_mixed_direction();
    load(8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i < 5) drive(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
      else       drive(1'b1, 2'b10, 1'b0, 1'b1, 8'h00);
      step();
      checks++;
      if (bus.word_done !== (i == 7) || bus.cnt !== 3'((i + 1) % 8)) begin
        failures++;
        $display("FAIL mixed_shift%0d: wd=%b cnt=%0d required %b/%0d",
                 i + 1, bus.word_done, bus.cnt, (i == 7), (i + 1) % 8);
      end
    end
    // 5 right shifts of 1 into 00 -> f8, then 3 left shifts of 1 -> c7
    checks++;
    if (bus.out !== 8'hC7) begin
      failures++;
      $display("FAIL mixed_out: got %h required c7", bus.out);
    end
  endtask

  task automatic test_mid_reset();
    load(8'h00);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.cnt !== 3'd0 || bus.word_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: cnt=%0d wd=%b required 0/0", bus.cnt, bus.word_done);
    end
    #2 rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (bus.word_done !== (i == 7)) begin
        failures++;
        $display("FAIL after_reset_shift%0d: wd=%b required %b", i + 1, bus.word_done, (i == 7));
      end
    end
  endtask

  task automatic test_back_to_back();
    // Continues shifting straight after a completed word.
    drive(1'b1, 2'b10, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (bus.word_done !== (i == 7) || bus.cnt !== 3'((i + 1) % 8)) begin
        failures++;
        $display("FAIL b2b_shift%0d: wd=%b cnt=%0d required %b/%0d",
                 i + 1, bus.word_done, bus.cnt, (i == 7), (i + 1) % 8);
      end
    end
    checks++;
    if (bus.out !== 8'hFF) begin
      failures++;
      $display("FAIL b2b_out: got %h required ff", bus.out);
    end
    drive(1'b0, 2'b10, 1'b0, 1'b0, 8'h00);
    step();
    checks++;
    if (bus.word_done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_pulse_width: wd=%b required 0", bus.word_done);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    test_reset();
    test_load_right();
    test_left();
    test_enable_low();
    test_load_interrupt();
    test_mixed_direction();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits; legal values are WIDTH >= 2.
REQ-002 The block SHALL have parameter RST_VAL, default all zeros, WIDTH bits, giving the value loaded into `out` on reset.
REQ-003 The block SHALL have port `clk`, input, 1 bit; it is the single clock and all state changes on its rising edge.
REQ-004 The block SHALL have port `rst`, input, 1 bit; it is an asynchronous, active-low reset.
REQ-005 The block SHALL have port `en`, input, 1 bit, a clock enable.
REQ-006 The block SHALL have port `mode`, input, 2 bits, with encodings:
- 00: hold
- 01: shift right
- 10: shift left
- 11: parallel load
REQ-007 The block SHALL have port `sin_r`, input, 1 bit, the serial input that enters the MSB on a right shift.
REQ-008 The block SHALL have port `sin_l`, input, 1 bit, the serial input that enters the LSB on a left shift.
REQ-009 The block SHALL have port `pin`, input, WIDTH bits, the parallel load data.
REQ-010 The block SHALL have port `out`, output, WIDTH bits, the register contents.
REQ-011 The block SHALL have port `so_r`, output, 1 bit, equal to out[0]; this is the right-shift serial output.
REQ-012 The block SHALL have port `so_l`, output, 1 bit, equal to out[WIDTH-1]; this is the left-shift serial output.
REQ-013 The block SHALL have port `cnt`, output, clog2(WIDTH) bits, the number of shifts since the last load, wrap or reset.
REQ-014 The block SHALL have port `word_done`, output, 1 bit, a registered pulse marking completion of a WIDTH-shift word.

Function
REQ-015 All state (`out`, `cnt`, `word_done`) SHALL be edge-triggered flip-flops on the rising edge of `clk`; no level-sensitive latches.
REQ-016 `so_r` and `so_l` SHALL be combinational copies of `out` bits, with no additional delay.
REQ-017 With `en`=0, `out` and `cnt` SHALL hold, and `word_done` SHALL be 0 on the next edge, regardless of `mode`.
REQ-018 With `en`=1 and `mode`=00, `out` and `cnt` SHALL hold, and `word_done` SHALL be 0 on the next edge.
REQ-019 With `en`=1 and `mode`=01, `out` SHALL become {sin_r, out[WIDTH-1:1]}, and `cnt` SHALL advance per REQ-022.
REQ-020 With `en`=1 and `mode`=10, `out` SHALL become {out[WIDTH-2:0], sin_l}, and `cnt` SHALL advance per REQ-022.
REQ-021 With `en`=1 and `mode`=11, `out` SHALL become `pin`, `cnt` SHALL become 0, and `word_done` SHALL become 0.
REQ-022 On each shift edge, `cnt` SHALL increment by 1, except that when `cnt`=WIDTH-1 it SHALL wrap to 0 and `word_done` SHALL be 1 for exactly that following cycle.
REQ-023 `word_done` SHALL be 0 on every edge that does not perform a wrapping shift; back-to-back words therefore produce a pulse every WIDTH shift edges.
REQ-024 A direction change mid-word (01 <-> 10) SHALL NOT clear `cnt`; shifts in both directions count toward the same word.
REQ-025 A parallel load SHALL take priority over any word in progress; the partial count is discarded and no `word_done` is issued.
REQ-026 Shift latency SHALL be one edge: the serial input value present at edge N appears in `out` after edge N.

Reset
REQ-027 While `rst`=0, the block SHALL immediately, without waiting for `clk`, force `out`=RST_VAL, `cnt`=0 and `word_done`=0.
REQ-028 Reset asserted mid-word SHALL abandon the word; after release, a full WIDTH shifts SHALL be required before the next `word_done`.
REQ-029 The first rising edge after `rst` returns to 1 SHALL operate normally per REQ-017 to REQ-025.

Verification (WIDTH=8, RST_VAL=0)
REQ-030 Reset: pulse `rst`=0 between clock edges -> `out`=0x00, `cnt`=0 and `word_done`=0 immediately.
REQ-031 Load and right shift: load `pin`=0xA5, then 8 edges with mode=01 and sin_r=1 ->
- `so_r` before each edge reads 1,0,1,0,0,1,0,1
- final `out`=0xFF and `cnt`=0
- `word_done`=1 for exactly the cycle after the 8th shift
REQ-032 Left shift: from 0x00, 4 edges with mode=10 and sin_l=1,1,0,0 -> `out`=0x0C and `cnt`=4.
REQ-033 Enable low: load 0x3C, then 3 edges with en=0 and mode=01 -> `out`=0x3C, `cnt`=0 and `word_done`=0 throughout.
REQ-034 Load interrupts word: after 6 right shifts, load `pin`=0x81 -> `cnt`=0 and `out`=0x81; 2 further shifts -> no `word_done`, `cnt`=2.
REQ-035 Mixed direction and mid-word reset:
- 5 right shifts then 3 left shifts -> `word_done` pulses after the 8th shift
- separately, `rst`=0 after 5 shifts -> `cnt`=0 at once; after release, 7 shifts give no pulse and the 8th gives the pulse
